uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 clk  input  1  system clock, same clock driving the uart block (16x baud).
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 req_valid  input  4  per-requester byte-pending flag; bit i = requester i.
REQ-004 req_data  input  32  requester i byte on bits [8i+7:8i].
REQ-005 req_ready  output  4  one-hot; byte i captured at this clock edge.
REQ-006 req_done  output  4  one-hot, 1-cycle pulse; requester's byte fully shifted out.
REQ-007 tx_start  output  1  to uart tx_start.
REQ-008 tx_data  output  8  to uart tx_data; registered.
REQ-009 tx_done  input  1  from uart; high for the whole stop bit (16 clk).
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 owner  output  2  index of the requester whose byte is in tx_data.

Function
REQ-012 States: IDLE, SEND, DRAIN; tx_done registered once (done_q); rise = tx_done & ~done_q.
REQ-013 IDLE: any req_valid -> grant g per REQ-017; req_ready[g]=1 combinationally that cycle; at the edge tx_data<=req_data[g], owner<=g, tx_start<=1, state->SEND.
REQ-014 SEND: tx_start held 1, tx_data held stable; on rise: req_done[owner] pulses 1 cycle; if any req_valid, grant/capture as REQ-013 in the same cycle, keep tx_start=1, stay SEND (chained frame, no idle bit); else tx_start<=0, state->DRAIN.
REQ-015 DRAIN: tx_start=0; leave to IDLE when tx_done=0; req_valid ignored.
REQ-016 tx_data never changes between the tx_start assertion and the following rise; decision after rise is made within 2 clk (stop bit lasts 16).
REQ-017 Arbitration round-robin: search starts at (last granted + 1) mod 4, first valid wins; pointer updates only on grant.
REQ-018 req_ready is only asserted in IDLE, or in SEND during the rise cycle; at most one bit high.
REQ-019 Requester holds req_valid and req_data stable until its req_ready; dropping valid early is legal, byte not sent.
REQ-020 tx_done rising while IDLE or DRAIN is ignored (no req_done).
REQ-021 Chained SEND entered with tx_done still high does not fire rise until tx_done falls and rises again.

Reset
REQ-022 rst_n low: state IDLE, tx_start=0, tx_data=0, owner=0, done_q=0, pointer=3 (requester 0 searched first), req_ready=0, req_done=0, busy=0.
REQ-023 Reset mid-frame aborts silently (no req_done); uart_tx_arb and uart are reset together by the system.

Configuration
REQ-024 Macro UART_ARB_PRIO_EN defined: requester 0 wins whenever req_valid[0]=1; requesters 1-3 round-robin among themselves when req_valid[0]=0.
REQ-025 UART_ARB_PRIO_EN undefined: pure 4-way round-robin per REQ-017.

Verification
REQ-026 Single: reset, req_valid=0001, data 0x55 -> req_ready=0001 same cycle, tx_start next edge, serial line 0,1,0,1,0,1,0,1,0,1 per 16 clk, req_done=0001 at tx_done rise, busy falls after stop.
REQ-027 Round-robin: all 4 valid, bytes 0xA0-0xA3 -> grant order 0,1,2,3, four back-to-back frames, no idle bit between frames, tx_start never low.
REQ-028 Data hold: requester 1 changes req_data mid-frame after ready -> serial byte unchanged; tx_data constant from tx_start to rise.
REQ-029 Late request: req_valid[2] rises in DRAIN -> no grant until tx_done=0, then IDLE grant, one stop+idle gap.
REQ-030 Priority (UART_ARB_PRIO_EN): req_valid[0] held with 3 always valid -> grants 0,0,0, never 3; without macro -> 0,3,0,3.
REQ-031 Reset: rst_n low during bit 4 -> tx_start=0, busy=0 immediately, no req_done; after release, req_valid=1000 -> frame for requester 3.

Source files
------------

// File: rtl/uart_tx_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_arb_if                                               |
// | Description : Bundle of signals between four byte requesters, the          |
// |               uart_tx_arb arbiter and the downstream UART transmitter.     |
// |   req_valid[3:0]  requester -> arb : byte pending, bit i = requester i     |
// |   req_data[31:0]  requester -> arb : requester i byte on [8i+7:8i]         |
// |   req_ready[3:0]  arb -> requester : one-hot, byte captured this edge      |
// |   req_done[3:0]   arb -> requester : one-hot pulse, byte fully shifted     |
// |   tx_start        arb -> uart      : start / keep transmitting             |
// |   tx_data[7:0]    arb -> uart      : byte to shift, registered             |
// |   tx_done         uart -> arb      : high for the whole stop bit           |
// |   busy            arb -> system    : arbiter not idle                      |
// |   owner[1:0]      arb -> system    : requester whose byte is in tx_data    |
// | Modports    : master = requesters/uart side, slave = arbiter side          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface uart_tx_arb_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  req_done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [1:0]  owner;

  modport master (
    output req_valid, req_data, tx_done,
    input  req_ready, req_done, tx_start, tx_data, busy, owner
  );

  modport slave (
    input  req_valid, req_data, tx_done,
    output req_ready, req_done, tx_start, tx_data, busy, owner
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_arb                                                  |
// | Description : Four-requester round-robin arbiter in front of a UART        |
// |               transmitter. Captures one byte per grant, holds it on        |
// |               tx_data for the whole frame and chains the next frame        |
// |               without an idle bit when another request is pending at the   |
// |               start of the stop bit.                                       |
// | Ports       : clk    - system clock (same 16x clock as the UART)           |
// |               rst_n  - asynchronous active-low reset                       |
// |               bus    - uart_tx_arb_if.slave (requester + UART signals)     |
// | Options     : UART_ARB_PRIO_EN - when defined, requester 0 has absolute    |
// |               priority and requesters 1-3 round-robin among themselves.    |
// |               When undefined, plain 4-way round-robin.                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module uart_tx_arb (
  input logic          clk,
  input logic          rst_n,
  uart_tx_arb_if.slave bus
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_SEND  = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;

  logic [1:0] r_state;
  logic       r_done_q;
  logic [1:0] r_ptr;
  logic       r_tx_start;
  logic [7:0] r_tx_data;
  logic [1:0] r_owner;

  logic       w_rise;
  logic [3:0] w_cand;
  logic       w_rr_vld;
  logic [1:0] w_rr_idx;
  logic [1:0] w_try;
  logic       w_grant_vld;
  logic [1:0] w_grant_idx;
  logic       w_take;
  logic [7:0] w_grant_byte;

  // Only the first cycle of the stop bit counts; a chained frame entered
  // while tx_done is still high waits for the next low-to-high transition.
  assign w_rise = bus.tx_done & ~r_done_q;

  // Round-robin search from (last granted + 1). Iterating from the farthest
  // candidate down to the nearest lets the nearest valid one win.
  always_comb begin
    w_cand = bus.req_valid;
`ifdef UART_ARB_PRIO_EN
    w_cand[0] = 1'b0;
`endif
    w_rr_vld = 1'b0;
    w_rr_idx = r_ptr;
    w_try    = r_ptr;
    for (int k = 4; k >= 1; k--) begin
      w_try = r_ptr + 2'(k);
      if (w_cand[w_try]) begin
        w_rr_vld = 1'b1;
        w_rr_idx = w_try;
      end
    end
  end

  always_comb begin
    w_grant_vld = w_rr_vld;
    w_grant_idx = w_rr_idx;
`ifdef UART_ARB_PRIO_EN
    if (bus.req_valid[0]) begin
      w_grant_vld = 1'b1;
      w_grant_idx = 2'd0;
    end
`endif
  end

  // A grant is taken when idle, or at the start of the stop bit of the
  // current frame so the next frame follows with no idle bit.
  assign w_take = w_grant_vld &
                  ((r_state == c_ST_IDLE) | ((r_state == c_ST_SEND) & w_rise));

  assign w_grant_byte = bus.req_data[{w_grant_idx, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_ST_IDLE;
      r_done_q   <= 1'b0;
      r_ptr      <= 2'd3;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'd0;
      r_owner    <= 2'd0;
    end else begin
      r_done_q <= bus.tx_done;
      if (w_take) begin
        r_tx_data  <= w_grant_byte;
        r_owner    <= w_grant_idx;
        r_ptr      <= w_grant_idx;
        r_tx_start <= 1'b1;
        r_state    <= c_ST_SEND;
      end else begin
        case (r_state)
          c_ST_IDLE: begin
          end
          c_ST_SEND: begin
            if (w_rise) begin
              r_tx_start <= 1'b0;
              r_state    <= c_ST_DRAIN;
            end
          end
          c_ST_DRAIN: begin
            // Wait out the stop bit so a new frame never overlaps it.
            if (!bus.tx_done) begin
              r_state <= c_ST_IDLE;
            end
          end
          default: begin
            r_tx_start <= 1'b0;
            r_state    <= c_ST_IDLE;
          end
        endcase
      end
    end
  end

  // Ready is combinational so the requester sees it in the capture cycle;
  // it is forced low while reset is asserted.
  assign bus.req_ready = (w_take & rst_n) ? (4'b0001 << w_grant_idx) : 4'b0000;
  assign bus.req_done  = ((r_state == c_ST_SEND) & w_rise) ? (4'b0001 << r_owner) : 4'b0000;
  assign bus.tx_start  = r_tx_start;
  assign bus.tx_data   = r_tx_data;
  assign bus.owner     = r_owner;
  assign bus.busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_arb                                               |
// | Description : Self-checking bench for uart_tx_arb. Contains a 16x UART     |
// |               transmitter model that drives tx_done and decodes the        |
// |               serial line, a rule-level reference of the arbiter, a        |
// |               vector table, directed corner sequences and a random phase.  |
// | Ports       : none                                                         |
// | Options     : UART_ARB_PRIO_EN selects the priority-mode expectations.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_uart_tx_arb;

`ifdef UART_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arb_if bus ();
  uart_tx_arb dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [3:0]  tb_valid = 4'b0000;
  logic [31:0] tb_data  = 32'd0;
  logic        u_done   = 1'b0;
  assign bus.req_valid = tb_valid;
  assign bus.req_data  = tb_data;
  assign bus.tx_done   = u_done;

  int n_cmp  = 0;
  int n_fail = 0;

  // UART model state
  bit         u_active = 1'b0;
  int         u_cnt    = 0;
  logic [7:0] u_byte   = 8'd0;
  logic [9:0] u_bits   = 10'd0;
  logic [7:0] u_last   = 8'd0;
  int         u_idle   = 0;
  int         n_frames = 0;

  // Reference state: what the arbiter should be doing according to its rules
  bit         m_busy  = 1'b0;
  bit         m_drain = 1'b0;
  int         m_ptr   = 3;
  int         m_owner = 0;
  bit         prev_done = 1'b0;
  logic [7:0] exp_bytes[$];

  // Samples and logs
  logic [3:0] s_ready, s_done;
  logic       s_start, s_busy;
  logic [7:0] s_txdata;
  int         g_log[$];
  bit         g_busy_at_grant = 1'b0;
  int         n_done = 0;
  int         start_low = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          exp_rr;
    int          exp_pr;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int ptr);
    int w;
    int idx;
    w = -1;
    if (PRIO && v[0]) return 0;
    for (int k = 1; k <= 4; k++) begin
      idx = (ptr + k) % 4;
      if (w < 0 && v[idx] && !(PRIO && idx == 0)) w = idx;
    end
    return w;
  endfunction

  function automatic int first_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic u_line(input int cnt, input logic [7:0] b);
    int bi;
    bi = cnt / 16;
    if (bi == 0) return 1'b0;
    if (bi == 9) return 1'b1;
    return b[bi-1];
  endfunction

  // One clock: check at the falling edge, then advance the UART model and
  // requester handshake just after the rising edge.
  task automatic tick();
    logic       rise, decide;
    logic [3:0] exp_rdy, exp_dn;
    int         w;
    @(negedge clk);
    s_ready  = bus.req_ready;
    s_done   = bus.req_done;
    s_start  = bus.tx_start;
    s_txdata = bus.tx_data;
    s_busy   = bus.busy;
    if (!rst_n) begin
      m_busy = 0; m_drain = 0; m_ptr = 3; m_owner = 0; prev_done = 0;
      exp_bytes.delete();
    end else begin
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("tx_start", 32'(bus.tx_start), 32'(m_busy && !m_drain));
      if (m_busy) check("owner", 32'(bus.owner), 32'(m_owner));
      if (u_active && u_cnt <= 144) check("tx_data_hold", 32'(bus.tx_data), 32'(u_byte));
      rise    = u_done && !prev_done;
      decide  = !m_busy || (!m_drain && rise);
      exp_dn  = (m_busy && !m_drain && rise) ? (4'b0001 << m_owner) : 4'b0000;
      exp_rdy = (decide && |tb_valid) ? (4'b0001 << rr_pick(tb_valid, m_ptr)) : 4'b0000;
      check("req_done", 32'(s_done), 32'(exp_dn));
      check("req_ready", 32'(s_ready), 32'(exp_rdy));
      if (s_ready != 0) begin
        g_log.push_back(first_idx(s_ready));
        g_busy_at_grant = s_busy;
      end
      if (s_done != 0) n_done++;
      if (s_busy && !s_start) start_low++;
      if (m_drain && !u_done) begin
        m_busy = 0; m_drain = 0;
      end else if (decide && |tb_valid) begin
        w = rr_pick(tb_valid, m_ptr);
        m_ptr = w; m_owner = w; m_busy = 1;
        exp_bytes.push_back(tb_data[8*w +: 8]);
      end else if (m_busy && !m_drain && rise) begin
        m_drain = 1;
      end
      prev_done = u_done;
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      u_active = 0; u_cnt = 0;
    end else begin
      if (u_active) begin
        if (u_cnt % 16 == 8) u_bits[u_cnt/16] = u_line(u_cnt, u_byte);
        if (u_cnt == 159) begin
          u_active = 0;
          u_last = u_bits[8:1];
          n_frames++;
          check("start_bit", 32'(u_bits[0]), 32'd0);
          check("stop_bit", 32'(u_bits[9]), 32'd1);
          if (exp_bytes.size() == 0) check("serial_unexpected", 32'(u_last), 32'hFFFF);
          else check("serial_byte", 32'(u_last), 32'(exp_bytes.pop_front()));
        end else begin
          u_cnt++;
        end
      end
      if (!u_active && s_start) begin
        u_active = 1; u_cnt = 0; u_byte = s_txdata;
      end else if (!u_active) begin
        u_idle++;
      end
    end
    u_done   = u_active && (u_cnt >= 144);
    tb_valid = tb_valid & ~s_ready;
  endtask

  task automatic do_reset();
    tb_valid = 4'b0000;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 2000 && (bus.busy || u_active); c++) tick();
    check(name, 32'(bus.busy || u_active), 32'd0);
  endtask

  int rem[4];
  int cd[4];
  int base;

  initial begin
    tbl[0] = '{4'b0001, 32'h00000055, 0, 0};
    tbl[1] = '{4'b1111, 32'hA3A2A1A0, 1, 0};
    tbl[2] = '{4'b1001, 32'h3C0000C3, 3, 0};
    tbl[3] = '{4'b0110, 32'h00F00F00, 1, 1};
    tbl[4] = '{4'b0101, 32'h00810018, 2, 0};
    tbl[5] = '{4'b1000, 32'hE7000000, 3, 3};
    tbl[6] = '{4'b0011, 32'h00006699, 0, 0};

    // Reset values, with a request pending to show ready is held low.
    #2;
    tb_valid = 4'b0001;
    rst_n = 1'b0;
    #1;
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_owner", 32'(bus.owner), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_req_done", 32'(bus.req_done), 32'd0);
    tick();
    tick();
    tb_valid = 4'b0000;
    rst_n = 1'b1;
    tick();

    // Vector table: one isolated frame per entry.
    for (int v = 0; v < 7; v++) begin
      int e;
      e = PRIO ? tbl[v].exp_pr : tbl[v].exp_rr;
      tb_valid = tbl[v].valid;
      tb_data  = tbl[v].data;
      tick();
      tb_valid = 4'b0000;
      check("tbl_ready", 32'(s_ready), 32'(4'b0001 << e));
      check("tbl_owner", 32'(bus.owner), 32'(e));
      check("tbl_tx_data", 32'(bus.tx_data), 32'(tbl[v].data[8*e +: 8]));
      wait_idle("tbl_frame_end");
      check("tbl_serial", 32'(u_last), 32'(tbl[v].data[8*e +: 8]));
    end

    // Four back-to-back chained frames, grant order 0,1,2,3.
    do_reset();
    g_log.delete();
    start_low = 0;
    base = n_done;
    tb_valid = 4'hF;
    tb_data  = 32'hA3A2A1A0;
    for (int c = 0; c < 1200 && (n_done - base) < 4; c++) tick();
    check("chain_done_count", 32'(n_done - base), 32'd4);
    check("chain_start_low", 32'(start_low), 32'd0);
    for (int k = 0; k < 4; k++)
      check("chain_order", 32'(g_log.size() > k ? g_log[k] : -1), 32'(k));
    wait_idle("chain_end");
    check("chain_last_byte", 32'(u_last), 32'hA3);

    // Requester 1 changes its data after being granted.
    tb_valid = 4'b0010;
    tb_data  = 32'h00003C00;
    tick();
    tb_valid = 4'b0000;
    repeat (30) tick();
    tb_data = 32'h0000C300;
    check("hold_tx_data", 32'(bus.tx_data), 32'h3C);
    wait_idle("hold_end");
    check("hold_serial", 32'(u_last), 32'h3C);

    // Late request arriving while draining the stop bit.
    do_reset();
    g_log.delete();
    tb_valid = 4'b0001;
    tb_data  = 32'h0000005A;
    tick();
    tb_valid = 4'b0000;
    for (int c = 0; c < 400 && !(bus.busy && !bus.tx_start); c++) tick();
    check("late_in_drain", 32'(bus.busy && !bus.tx_start), 32'd1);
    tb_valid = 4'b0100;
    tb_data  = 32'h00A50000;
    u_idle = 0;
    for (int c = 0; c < 400 && g_log.size() < 2; c++) tick();
    check("late_grants", 32'(g_log.size()), 32'd2);
    check("late_winner", 32'(g_log.size() > 1 ? g_log[1] : -1), 32'd2);
    check("late_grant_idle", 32'(g_busy_at_grant), 32'd0);
    wait_idle("late_end");
    check("late_gap", 32'(u_idle > 0), 32'd1);
    check("late_serial", 32'(u_last), 32'hA5);

    // Requester 0 keeps requesting while requester 3 always waits.
    do_reset();
    g_log.delete();
    tb_valid = 4'b1001;
    tb_data  = 32'h33000011;
    for (int c = 0; c < 2000 && g_log.size() < 3; c++) begin
      tick();
      tb_valid = tb_valid | 4'b1001;
    end
    tb_valid = 4'b0000;
    for (int k = 0; k < 3; k++)
      check("prio_order", 32'(g_log.size() > k ? g_log[k] : -1),
            32'(PRIO ? 0 : ((k % 2 == 1) ? 3 : 0)));
    wait_idle("prio_end");

    // Reset during data bit 4 of a frame.
    do_reset();
    base = n_done;
    tb_valid = 4'b0001;
    tb_data  = 32'h000000F0;
    tick();
    tb_valid = 4'b0000;
    for (int c = 0; c < 300 && !(u_active && u_cnt >= 64); c++) tick();
    check("rst_mid_reached", 32'(u_active && u_cnt >= 64 && u_cnt < 80), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_done", 32'(bus.req_done), 32'd0);
    tick();
    tick();
    check("rst_mid_no_done", 32'(n_done - base), 32'd0);
    rst_n = 1'b1;
    g_log.delete();
    tb_valid = 4'b1000;
    tb_data  = 32'h69000000;
    tick();
    tb_valid = 4'b0000;
    check("rst_after_ready", 32'(s_ready), 32'b1000);
    wait_idle("rst_after_end");
    check("rst_after_serial", 32'(u_last), 32'h69);

    // Random traffic: six bytes per requester with random gaps.
    do_reset();
    base = n_frames;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 6;
      cd[i]  = $urandom_range(0, 200);
    end
    for (int c = 0; c < 20000; c++) begin
      if ((rem[0] + rem[1] + rem[2] + rem[3]) == 0 && tb_valid == 0 && !bus.busy && !u_active) break;
      for (int i = 0; i < 4; i++) begin
        if (!tb_valid[i] && rem[i] > 0) begin
          if (cd[i] == 0) begin
            tb_valid[i] = 1'b1;
            tb_data[8*i +: 8] = 8'($urandom);
            rem[i]--;
            cd[i] = $urandom_range(0, 250);
          end else begin
            cd[i]--;
          end
        end
      end
      tick();
    end
    check("rand_frames", 32'(n_frames - base), 32'd24);
    check("rand_queue_empty", 32'(exp_bytes.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
